// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter between a single-cycle ALU and a queued MDU
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_dest,
    input  logic [31:0]                   alu_data,
    input  logic                          mdu_valid,
    output logic                          mdu_ready,
    input  logic [4:0]                    mdu_dest,
    input  logic [31:0]                   mdu_data,
    output logic                          we,
    output logic [4:0]                    write_address,
    output logic [31:0]                   data,
    output logic                          alu_stall,
    output logic [31:0]                   pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [4:0]    q_dest [FIFO_DEPTH];
    logic [31:0]   q_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    wait_cnt;

    logic q_empty;
    logic alu_ok;
    logic issue_alu;
    logic pop;
    logic store;
    logic [PW-1:0] idx;

    assign q_empty   = (fifo_count == '0);
    assign mdu_ready = (fifo_count < DEPTH_C) && !reset;
    assign alu_ok    = alu_valid && (alu_dest != 5'd0);
    // A pending forced issue wins over the ALU and also masks it out.
    assign pop       = !q_empty && (alu_stall || !alu_ok);
    assign issue_alu = alu_ok && !alu_stall;
    // Dest-0 MDU results complete the handshake but are never queued.
    assign store     = mdu_valid && mdu_ready && (mdu_dest != 5'd0);

    always_comb begin
        pend_mask = '0;
        idx       = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < fifo_count) begin
                pend_mask[q_dest[idx]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we            <= 1'b0;
            write_address <= '0;
            data          <= '0;
            alu_stall     <= 1'b0;
            wait_cnt      <= '0;
            fifo_count    <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            we <= pop || issue_alu;
            if (pop) begin
                write_address <= q_dest[rd_ptr];
                data          <= q_data[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end else if (issue_alu) begin
                write_address <= alu_dest;
                data          <= alu_data;
            end

            if (store) begin
                q_dest[wr_ptr] <= mdu_dest;
                q_data[wr_ptr] <= mdu_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end

            case ({store, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (pop || q_empty) begin
                wait_cnt <= '0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            alu_stall <= (wait_cnt == LIMIT - 8'd1) && !q_empty && !pop;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed bench for wb_arbiter against a queue-level reference model
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_data;
    logic        we;
    logic [4:0]  write_address;
    logic [31:0] data;
    logic        alu_stall;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
        .we(we), .write_address(write_address), .data(data),
        .alu_stall(alu_stall), .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the queue is an SV queue, the write port is whatever was chosen last edge.
    logic [4:0]  mq_dest[$];
    logic [31:0] mq_data[$];
    logic        m_we, m_stall, m_popped, m_alu_ok;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pend;
    int          m_wait, m_sz;

    initial begin
        m_we = 0; m_addr = 0; m_data = 0; m_stall = 0; m_wait = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            mq_dest.delete();
            mq_data.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_stall = 0; m_wait = 0;
        end else begin
            m_sz     = mq_dest.size();
            m_alu_ok = alu_valid && (alu_dest != 0);
            m_popped = 0;
            if (m_sz > 0 && (m_stall || !m_alu_ok)) begin
                m_popped = 1;
                m_we     = 1;
                m_addr   = mq_dest.pop_front();
                m_data   = mq_data.pop_front();
            end else if (m_alu_ok && !m_stall) begin
                m_we   = 1;
                m_addr = alu_dest;
                m_data = alu_data;
            end else begin
                m_we = 0;
            end
            if (mdu_valid && m_sz < DEPTH && mdu_dest != 0) begin
                mq_dest.push_back(mdu_dest);
                mq_data.push_back(mdu_data);
            end
            m_stall = (m_wait == LIMIT - 1) && (m_sz > 0) && !m_popped;
            if (m_popped || m_sz == 0) m_wait = 0;
            else if (m_wait < LIMIT)   m_wait = m_wait + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            m_pend = 0;
            foreach (mq_dest[i]) m_pend[mq_dest[i]] = 1'b1;
            m_pend[0] = 1'b0;
            chk("cyc_we", we, m_we);
            chk("cyc_addr", write_address, m_addr);
            chk("cyc_data", data, m_data);
            chk("cyc_stall", alu_stall, m_stall);
            chk("cyc_count", fifo_count, 32'(mq_dest.size()));
            chk("cyc_pend", pend_mask, m_pend);
            chk("cyc_ready", mdu_ready, (!reset && mq_dest.size() < DEPTH));
        end
    end

    task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adt,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdt);
        @(posedge clk);
        #2;
        alu_valid = av; alu_dest = ad; alu_data = adt;
        mdu_valid = mv; mdu_dest = md; mdu_data = mdt;
    endtask

    task automatic obs();
        @(negedge clk);
        #1;
    endtask

    int first_k, stall_n;

    initial begin
        reset = 1;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        mdu_valid = 0; mdu_dest = 0; mdu_data = 0;
        @(posedge clk);
        #2 chk_en = 1;
        obs();
        chk("rst_we", we, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", mdu_ready, 0);
        chk("rst_pend", pend_mask, 0);
        @(posedge clk);
        #2 reset = 0;
        obs();
        chk("ready_after_rst", mdu_ready, 1);

        // ALU only, then a dest-0 ALU result that must not write
        drive(1, 5'd5, 32'h1234, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        obs();
        chk("alu_we", we, 1);
        chk("alu_addr", write_address, 5);
        chk("alu_data", data, 32'h1234);
        drive(1, 5'd0, 32'hDEAD, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        obs();
        chk("dest0_we", we, 0);
        chk("dest0_hold_addr", write_address, 5);
        chk("dest0_hold_data", data, 32'h1234);

        // Fill while the ALU owns the port, then drain
        for (int i = 1; i <= 4; i++) drive(1, 5'(9 + i), 32'h9000 + i, 1, 5'(i), 32'h100 + i);
        drive(0, 0, 0, 1, 5'd6, 32'h666);
        obs();
        chk("full_count", fifo_count, 4);
        chk("full_ready", mdu_ready, 0);
        chk("full_pend", pend_mask, 32'h1E);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            obs();
            chk("drain_we", we, 1);
            chk("drain_addr", write_address, i);
            chk("drain_data", data, 32'h100 + i);
            if (i == 1) chk("drain_ready", mdu_ready, 1);
        end

        // ALU priority over a queued entry
        drive(0, 0, 0, 1, 5'd7, 32'h77);
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        obs();
        chk("prio_pend7", pend_mask, 32'h80);
        drive(0, 0, 0, 0, 0, 0);
        obs();
        chk("prio_first", write_address, 9);
        chk("prio_first_data", data, 32'h99);
        drive(0, 0, 0, 0, 0, 0);
        obs();
        chk("prio_second", write_address, 7);
        chk("prio_second_data", data, 32'h77);
        chk("prio_pend_clear", pend_mask, 0);

        // Starvation: one entry behind a continuously valid ALU
        drive(1, 5'd20, 32'hA000, 1, 5'd3, 32'h33);
        first_k = 0;
        stall_n = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(1, 5'd20, 32'hA000, 0, 0, 0);
            obs();
            if (alu_stall) begin
                stall_n++;
                if (first_k == 0) first_k = k;
            end
            if (k == 10) begin
                chk("starve_entry_addr", write_address, 3);
                chk("starve_entry_data", data, 32'h33);
            end
            if (k == 11) begin
                chk("starve_alu_we", we, 1);
                chk("starve_alu_addr", write_address, 20);
            end
        end
        chk("starve_first_cycle", first_k, 9);
        chk("starve_once", stall_n, 1);

        // Concurrent push/pop at depth 2, through pointer wrap
        drive(1, 5'd21, 32'h21, 1, 5'd11, 32'hB1);
        drive(1, 5'd21, 32'h21, 1, 5'd12, 32'hB2);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 5'(13 + i), 32'hB3 + i);
            obs();
            chk("pp_count", fifo_count, 2);
            if (i > 0) begin
                chk("pp_addr", write_address, 10 + i);
                chk("pp_data", data, 32'hB0 + i);
            end
        end
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 0, 0, 0);
            obs();
            chk("pp_tail_addr", write_address, 14 + j);
            chk("pp_tail_data", data, 32'hB4 + j);
        end

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) drive(1, 5'd22, 32'h22, 1, 5'(24 + i), 32'hC0 + i);
        @(posedge clk);
        #2;
        reset = 1;
        alu_valid = 1; alu_dest = 5'd22; mdu_valid = 0;
        obs();
        chk("mrst_count_before", fifo_count, 3);
        chk("mrst_ready", mdu_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        obs();
        chk("mrst_we", we, 0);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_pend", pend_mask, 0);
        @(posedge clk);
        #2 reset = 0;
        for (int i = 0; i < 4; i++) begin
            obs();
            chk("mrst_no_stale", we, 0);
            @(posedge clk);
        end
        obs();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
